uart_tx_buffered: RTL and testbench

Buffered 8N1 UART transmitter. It is the stage feeding the board's UART TX pin from the message/sequencer logic in `top`.
- Upstream logic pushes bytes over a valid/ready handshake into a small FIFO.
- A serializer drains the FIFO onto `tx` at one bit per DIVIDER clocks.
- Back-to-back frames go out with no idle gap.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 60 ++++++
 rtl/uart_tx_buffered.sv | 127 ++++++++++++
 tb/tb_uart_tx_buffered.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Serializer state encoding and frame geometry live here.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting for the serializer.
// Read data is the entry at the read pointer; no write-to-read bypass.
module uart_tx_fifo #(
  parameter int AW = 2,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers are exactly AW bits wide so they wrap modulo depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: valid/ready byte intake, FIFO,
// and a serializer that sends frames back to back with no idle gap.
module uart_tx_buffered #(
  parameter int DIVIDER = 4,
  parameter int FIFO_AW = 2
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);

  import uart_pkg::*;

  localparam int BW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIVIDER - 1);
  localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

  uart_state_e state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          tick;
  logic [7:0]    rd_data;

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign tick     = (baud == BAUD_LAST);

  // Pop from IDLE, or at the end of a stop bit to chain frames.
  assign pop = !empty &&
               ((state == ST_IDLE) ||
                (state == ST_STOP && tick));

  assign busy = (fifo_count != '0) ||
                (state != ST_IDLE);

  uart_tx_fifo #(
    .AW (FIFO_AW),
    .W  (8)
  ) u_fifo (
    .clk   (CLK),
    .rst   (rst),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (rd_data),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state   <= ST_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          baud <= '0;
          tx   <= 1'b1;
          if (!empty) begin
            shreg <= rd_data;
            tx    <= 1'b0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            baud    <= '0;
            bit_cnt <= '0;
            tx      <= shreg[0];
            state   <= ST_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick) begin
            baud <= '0;
            if (bit_cnt == BIT_LAST) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        ST_STOP: begin
          if (tick) begin
            baud <= '0;
            if (!empty) begin
              shreg <= rd_data;
              tx    <= 1'b0;
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed and random pushes checked
// cycle by cycle against a frame-schedule model of the line.
module tb_uart_tx_buffered;

  localparam int DIV   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int FL    = 10 * DIV;

  logic          CLK = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          tx;
  logic          busy;
  logic [AW:0]   fifo_count;

  always #5 CLK = ~CLK;

  uart_tx_buffered #(
    .DIVIDER (DIV),
    .FIFO_AW (AW)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  int cyc;
  int tests;
  int fails;

  // Model: each accepted byte gets an acceptance edge and a frame
  // start edge; the line value follows from the frame schedule.
  int         acc_e [$];
  int         st_e  [$];
  logic [7:0] bq    [$];
  int         last_st;

  function automatic int m_count(int k);
    int n = 0;
    foreach (acc_e[i]) if (acc_e[i] <= k) n++;
    foreach (st_e[i]) if (st_e[i] <= k) n--;
    return n;
  endfunction

  function automatic bit m_inframe(int k);
    foreach (st_e[i])
      if (k >= st_e[i] && k < st_e[i] + FL) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_tx(int k);
    foreach (st_e[i]) begin
      if (k >= st_e[i] && k < st_e[i] + FL) begin
        int b;
        b = (k - st_e[i]) / DIV;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return bq[i][b-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic void accept(logic [7:0] d, int e);
    int s;
    s = (e + 1 > last_st + FL) ? e + 1 : last_st + FL;
    acc_e.push_back(e);
    st_e.push_back(s);
    bq.push_back(d);
    last_st = s;
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = m_count(cyc);
    chk("tx", {7'd0, tx}, {7'd0, m_tx(cyc)});
    chk("in_ready", {7'd0, in_ready}, {7'd0, n < DEPTH});
    chk("busy", {7'd0, busy},
        {7'd0, (n != 0) || m_inframe(cyc)});
    chk("fifo_count", {5'd0, fifo_count}, 8'(n));
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    bit ok;
    in_valid = v;
    in_data  = d;
    ok = m_count(cyc) < DEPTH;
    @(posedge CLK);
    cyc++;
    if (v && ok) accept(d, cyc);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge CLK);
    cyc++;
    #1;
    rst = 1'b0;
    acc_e.delete();
    st_e.delete();
    bq.delete();
    last_st = -1000;
    check_all();
  endtask

  task automatic drain();
    int n = 0;
    while ((m_count(cyc) != 0 || m_inframe(cyc)) && n < 3000) begin
      step(1'b0, 8'($urandom));
      n++;
    end
    repeat (3) step(1'b0, 8'($urandom));
  endtask

  initial begin
    int i;
    int guard;
    cyc      = 0;
    tests    = 0;
    fails    = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    last_st  = -1000;
    #2;
    do_reset();

    // Idle line with garbage on in_data while in_valid is low.
    repeat (100) step(1'b0, 8'($urandom));

    step(1'b1, 8'h55);
    drain();

    step(1'b1, 8'h41);
    step(1'b1, 8'h42);
    drain();

    // Hold valid high; bytes advance only when accepted.
    i = 0;
    guard = 0;
    while (i < 8 && guard < 1000) begin
      bit ok;
      ok = m_count(cyc) < DEPTH;
      step(1'b1, 8'(i));
      if (ok) i++;
      guard++;
    end
    chk("burst_accepted", 8'(i), 8'd8);
    drain();

    // Reset during data bit 3 with three bytes queued.
    step(1'b1, 8'hC3);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    chk("queued_before_rst", {5'd0, fifo_count}, 8'd3);
    guard = 0;
    while (cyc < st_e[0] + 4 * DIV + 1 && guard < 100) begin
      step(1'b0, 8'h00);
      guard++;
    end
    do_reset();
    chk("rst_tx", {7'd0, tx}, 8'd1);
    chk("rst_count", {5'd0, fifo_count}, 8'd0);
    step(1'b1, 8'hA5);
    drain();

    step(1'b1, 8'hFF);
    step(1'b1, 8'h00);
    drain();

    // Random traffic: dense then sparse.
    repeat (300) step($urandom_range(0, 3) != 0, 8'($urandom));
    drain();
    repeat (400) step($urandom_range(0, 9) == 0, 8'($urandom));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
